// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel array readout sequencer.
//   state_t      : sequencer phases
//   *_DEF        : default phase lengths and widths
//   max2()       : elaboration-time helper for sizing the shared phase counter
package pixel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ
  } state_t;

  localparam int N_ROWS_DEF   = 2;
  localparam int C_ERASE_DEF  = 5;
  localparam int C_READ_DEF   = 5;
  localparam int ADC_BITS_DEF = 8;
  localparam int EXP_W_DEF    = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Ramp ADC code generator: binary counter with a registered Gray-coded copy.
//   clk, reset : clock, async active-high reset (count and gray -> 0)
//   clear      : synchronous reload to 0 (start of a convert phase)
//   enable     : advance by one
//   gray       : b ^ (b >> 1); holds its value while neither clear nor enable
module gray_counter #(
  parameter int ADC_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [ADC_BITS-1:0] gray
);

  logic [ADC_BITS-1:0] bin;
  logic [ADC_BITS-1:0] bin_inc;

  assign bin_inc = bin + ADC_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin  <= '0;
      gray <= '0;
    end else if (clear) begin
      bin  <= '0;
      gray <= '0;
    end else if (enable) begin
      bin  <= bin_inc;
      gray <= bin_inc ^ (bin_inc >> 1);
    end
  end

endmodule

// File: rtl/pixel_sequencer.sv
// Pixel array frame sequencer: ERASE -> EXPOSE -> CONVERT -> READ (row by row).
//   clk, reset          : clock, async active-high reset
//   start, continuous   : frame request (single-shot / free-running), seen in IDLE
//   abort               : synchronous return to IDLE, highest priority
//   expose_len          : exposure cycles, latched at frame start (0 acts as 1)
//   row_ready           : downstream accepts the row flagged by row_valid
//   erase/expose/convert: registered phase strobes
//   read                : one-hot row read strobe
//   gray                : Gray-coded ramp code during CONVERT
//   row_valid, row_idx  : last read cycle of current row / current row index
//   frame_done          : one-cycle pulse after the last row handoff
//   busy                : high whenever not IDLE
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter int N_ROWS   = N_ROWS_DEF,
  parameter int C_ERASE  = C_ERASE_DEF,
  parameter int C_READ   = C_READ_DEF,
  parameter int ADC_BITS = ADC_BITS_DEF,
  parameter int EXP_W    = EXP_W_DEF,
  localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [EXP_W-1:0]    expose_len,
  input  logic                row_ready,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [N_ROWS-1:0]   read,
  output logic [ADC_BITS-1:0] gray,
  output logic                row_valid,
  output logic [RW-1:0]       row_idx,
  output logic                frame_done,
  output logic                busy
);

  // One counter times every phase, so it must span the longest of them.
  localparam int PH_MAX = max2(max2(C_ERASE, 2**EXP_W), max2(2**ADC_BITS, C_READ));
  localparam int CW     = $clog2(PH_MAX + 1);

  localparam logic [CW-1:0]     ERASE_LAST = CW'(C_ERASE - 1);
  localparam logic [CW-1:0]     CONV_LAST  = CW'(2**ADC_BITS - 1);
  localparam logic [CW-1:0]     READ_LAST  = CW'(C_READ - 1);
  localparam logic [RW-1:0]     LAST_ROW   = RW'(N_ROWS - 1);
  localparam logic [N_ROWS-1:0] READ_FIRST = N_ROWS'(1);

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [EXP_W-1:0]  exp_lat, exp_d;
  logic [CW-1:0]     exp_last;
  logic              erase_d, expose_d, convert_d, row_valid_d, frame_done_d;
  logic [N_ROWS-1:0] read_d;
  logic [RW-1:0]     row_idx_d;
  logic              go;
  logic              gc_clear, gc_en;

  assign exp_last = CW'(exp_lat) - CW'(1);
  assign busy     = (state != IDLE);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    exp_d        = exp_lat;
    erase_d      = erase;
    expose_d     = expose;
    convert_d    = convert;
    read_d       = read;
    row_idx_d    = row_idx;
    row_valid_d  = row_valid;
    frame_done_d = 1'b0;
    go           = 1'b0;
    gc_clear     = 1'b0;
    gc_en        = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      erase_d     = 1'b0;
      expose_d    = 1'b0;
      convert_d   = 1'b0;
      read_d      = '0;
      row_idx_d   = '0;
      row_valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: go = start | continuous;

        ERASE: begin
          if (cnt == ERASE_LAST) begin
            state_d  = EXPOSE;
            erase_d  = 1'b0;
            expose_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end

        EXPOSE: begin
          if (cnt == exp_last) begin
            state_d   = CONVERT;
            expose_d  = 1'b0;
            convert_d = 1'b1;
            cnt_d     = '0;
            gc_clear  = 1'b1;   // ramp code 0 on the first convert cycle
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end

        CONVERT: begin
          if (cnt == CONV_LAST) begin
            // Ramp is not advanced on the last cycle: gray keeps its final code.
            state_d     = READ;
            convert_d   = 1'b0;
            read_d      = READ_FIRST;
            row_idx_d   = '0;
            row_valid_d = (READ_LAST == '0);
            cnt_d       = '0;
          end else begin
            cnt_d = cnt + CW'(1);
            gc_en = 1'b1;
          end
        end

        READ: begin
          if (row_valid) begin
            // Last read cycle of the row: hold everything until accepted.
            if (row_ready) begin
              cnt_d = '0;
              if (row_idx == LAST_ROW) begin
                read_d       = '0;
                row_valid_d  = 1'b0;
                row_idx_d    = '0;
                frame_done_d = 1'b1;
                state_d      = IDLE;
                go           = continuous;
              end else begin
                read_d      = read << 1;
                row_idx_d   = row_idx + RW'(1);
                row_valid_d = (READ_LAST == '0);
              end
            end
          end else begin
            cnt_d       = cnt + CW'(1);
            row_valid_d = ((cnt + CW'(1)) == READ_LAST);
          end
        end

        default: state_d = IDLE;
      endcase

      if (go) begin
        state_d = ERASE;
        erase_d = 1'b1;
        cnt_d   = '0;
        exp_d   = (expose_len == '0) ? EXP_W'(1) : expose_len;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      exp_lat    <= EXP_W'(1);
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= '0;
      row_idx    <= '0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      exp_lat    <= exp_d;
      erase      <= erase_d;
      expose     <= expose_d;
      convert    <= convert_d;
      read       <= read_d;
      row_idx    <= row_idx_d;
      row_valid  <= row_valid_d;
      frame_done <= frame_done_d;
    end
  end

  gray_counter #(
    .ADC_BITS (ADC_BITS)
  ) u_gray (
    .clk    (clk),
    .reset  (reset),
    .clear  (gc_clear),
    .enable (gc_en),
    .gray   (gray)
  );

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer (N_ROWS=2, ADC_BITS=4, C_ERASE=C_READ=5).
module tb_pixel_sequencer;

  localparam int N_ROWS   = 2;
  localparam int ADC_BITS = 4;
  localparam int EXP_W    = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                continuous = 1'b0;
  logic                abort = 1'b0;
  logic [EXP_W-1:0]    expose_len = '0;
  logic                row_ready = 1'b1;
  logic                erase, expose, convert;
  logic [N_ROWS-1:0]   read;
  logic [ADC_BITS-1:0] gray;
  logic                row_valid;
  logic [0:0]          row_idx;
  logic                frame_done, busy;

  int errs = 0;
  int checks = 0;

  int n_er, n_ex, n_cv, n_r0, n_r1, n_busy, gi;
  logic [3:0] gseq [16];
  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  pixel_sequencer #(
    .N_ROWS   (N_ROWS),
    .C_ERASE  (5),
    .C_READ   (5),
    .ADC_BITS (ADC_BITS),
    .EXP_W    (EXP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .expose_len (expose_len),
    .row_ready  (row_ready),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read       (read),
    .gray       (gray),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count strobe cycles from the current sample until the next frame_done.
  task automatic collect(input int budget);
    bit done = 1'b0;
    n_er = 0; n_ex = 0; n_cv = 0; n_r0 = 0; n_r1 = 0; n_busy = 0; gi = 0;
    for (int k = 0; k < budget; k++) begin
      if (frame_done && k > 0) begin
        done = 1'b1;
        break;
      end
      if (erase) n_er++;
      if (expose) n_ex++;
      if (convert) begin
        if (gi < 16) gseq[gi] = gray;
        gi++;
        n_cv++;
      end
      if (read[0]) n_r0++;
      if (read[1]) n_r1++;
      if (busy) n_busy++;
      step();
    end
    chk("frame_end_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int held;

    // Reset state
    #3;
    chk("reset_outputs", {erase, expose, convert, read, row_valid, frame_done, busy, row_idx}, 32'd0);
    chk("reset_gray", 32'(gray), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    chk("idle_no_request", 32'(busy), 32'd0);

    // Single-shot frame, exposure 10, ready always high
    expose_len = 8'd10;
    row_ready  = 1'b1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    expose_len = 8'd99;   // must not affect this frame
    chk("first_erase", {erase, busy}, 32'b11);
    collect(200);
    chk("erase_cycles", 32'(n_er), 32'd5);
    chk("expose_cycles", 32'(n_ex), 32'd10);
    chk("convert_cycles", 32'(n_cv), 32'd16);
    chk("read0_cycles", 32'(n_r0), 32'd5);
    chk("read1_cycles", 32'(n_r1), 32'd5);
    chk("busy_cycles", 32'(n_busy), 32'd41);
    for (int i = 0; i < 16; i++) chk($sformatf("gray_seq_%0d", i), 32'(gseq[i]), 32'(gtab[i]));
    chk("done_cycle_idle", {busy, erase, read}, 32'd0);
    chk("gray_final", 32'(gray), 32'd8);
    step();
    chk("done_one_pulse", 32'(frame_done), 32'd0);
    chk("gray_hold", 32'(gray), 32'd8);

    // Stall on row 0, start pulse during the frame is ignored
    expose_len = 8'd1;
    row_ready  = 1'b0;
    start      = 1'b1;
    step();
    start      = 1'b0;
    for (int k = 0; k < 100 && !(row_valid && read == 2'b01); k++) step();
    chk("row0_valid_seen", {row_valid, read}, 32'b101);
    held = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
      if (read == 2'b01 && row_valid && row_idx == 1'b0) held++;
    end
    chk("stall_held", 32'(held), 32'd7);
    row_ready = 1'b1;
    step();
    chk("row1_after_stall", {read, row_idx, row_valid}, 32'b1010);
    for (int k = 0; k < 100 && !frame_done; k++) step();
    chk("stall_frame_done", 32'(frame_done), 32'd1);
    step(); step(); step();
    chk("start_not_queued", 32'(busy), 32'd0);

    // Continuous frames with zero exposure
    continuous = 1'b1;
    expose_len = 8'd0;
    step();
    collect(200);
    chk("cont_expose1", 32'(n_ex), 32'd1);
    chk("cont_busy", 32'(n_busy), 32'd32);
    chk("cont_no_gap", {frame_done, erase, busy}, 32'b111);
    collect(200);
    chk("cont2_erase", 32'(n_er), 32'd5);
    chk("cont2_expose1", 32'(n_ex), 32'd1);
    continuous = 1'b0;

    // Abort in the middle of convert
    for (int k = 0; k < 100 && !convert; k++) step();
    chk("conv_first_gray", {convert, gray}, 32'h10);
    step(); step(); step();
    chk("conv_pre_abort", 32'(gray), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {convert, busy, erase, expose, read, row_valid, frame_done}, 32'd0);
    chk("abort_gray_hold", 32'(gray), 32'd2);
    step();
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Asynchronous reset during READ
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && read == '0; k++) step();
    chk("reached_read", 32'(read), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {erase, expose, convert, read, row_valid, frame_done, busy, row_idx}, 32'd0);
    chk("async_reset_gray", 32'(gray), 32'd0);
    #1;
    reset = 1'b0;
    step();
    step();
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pixel_sequencer.md
PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have parameter N_ROWS, default 2, number of pixel rows read out sequentially (>=1).
REQ-002 SHALL have parameter C_ERASE, default 5, erase phase length in cycles (>=1).
REQ-003 SHALL have parameter C_READ, default 5, per-row read strobe length in cycles (>=1).
REQ-004 SHALL have parameter ADC_BITS, default 8, ramp ADC resolution; convert phase lasts 2^ADC_BITS cycles.
REQ-005 SHALL have parameter EXP_W, default 8, width of the programmable exposure length.
REQ-006 SHALL have port clk  input  1  single clock, rising-edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  single-shot frame request, sampled in IDLE only.
REQ-009 SHALL have port continuous  input  1  1 = free-running frames, 0 = single-shot.
REQ-010 SHALL have port abort  input  1  synchronous return to IDLE from any state.
REQ-011 SHALL have port expose_len  input  EXP_W  exposure cycles, latched at frame start.
REQ-012 SHALL have port row_ready  input  1  downstream bus accepts the current row.
REQ-013 SHALL have port erase, expose, convert  output  1 each  pixel array phase strobes.
REQ-014 SHALL have port read  output  N_ROWS  one-hot row read strobe.
REQ-015 SHALL have port gray  output  ADC_BITS  Gray-coded ramp counter to pixel latches.
REQ-016 SHALL have ports row_valid (1), row_idx (clog2(N_ROWS), min 1), frame_done (1), busy (1), all outputs.

Function
REQ-017 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ; all strobes are registered and low in IDLE.
REQ-018 IDLE -> ERASE when start=1 or continuous=1; expose_len latched that same edge; latched value 0 treated as 1.
REQ-019 ERASE: erase=1 for exactly C_ERASE cycles, then EXPOSE.
REQ-020 EXPOSE: expose=1 for exactly the latched exposure count, then CONVERT; expose_len changes mid-frame have no effect.
REQ-021 CONVERT: convert=1 for exactly 2^ADC_BITS cycles; binary counter b starts at 0 on first convert cycle, increments each cycle; gray = b ^ (b>>1).
REQ-022 gray SHALL hold its final value (MSB only set) after CONVERT until the next CONVERT begins; reset value 0.
REQ-023 READ: rows serviced in order 0..N_ROWS-1; read[row_idx]=1 for C_READ cycles minimum.
REQ-024 row_valid=1 on the last read cycle of a row; if row_ready=0 the sequencer stalls with read and row_valid held, row_idx stable.
REQ-025 Row handoff occurs on a cycle with row_valid=1 and row_ready=1; next cycle read advances to next row with no gap.
REQ-026 After last-row handoff: frame_done=1 for one cycle; next state ERASE if continuous=1 at that edge, else IDLE.
REQ-027 start asserted outside IDLE SHALL be ignored (not queued).
REQ-028 abort=1 SHALL force IDLE at the next edge, clear all strobes, row_valid, frame_done; abort has priority over every transition including frame-start; gray retains value.
REQ-029 busy=1 in every state except IDLE.
REQ-030 N_ROWS=1 SHALL work with row_idx held at 0.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, all counters 0, gray=0, read=0, row_idx=0, and all 1-bit outputs 0.
REQ-032 Release of reset mid-frame SHALL begin in IDLE; a new frame requires start or continuous.

Structure
REQ-033 State enum and phase-length defaults SHALL live in a shared package pixel_pkg.
REQ-034 Gray counter SHALL be a sub-module gray_counter (parameter ADC_BITS; clear, enable, gray out).
REQ-035 One shared phase counter sized to max(C_ERASE, 2^EXP_W, 2^ADC_BITS, C_READ) SHALL time all phases.

Verification
REQ-036 N_ROWS=2, ADC_BITS=4, expose_len=10, start pulse, row_ready=1 -> erase 5 cycles, expose 10, convert 16, read[0] 5, read[1] 5, frame_done once, IDLE.
REQ-037 Convert phase with ADC_BITS=4 -> gray sequence 0,1,3,2,6,...,8; holds 8 afterwards.
REQ-038 row_ready=0 for 7 cycles at row 0 last read -> read=01 and row_valid held 7 extra cycles, then read=10.
REQ-039 continuous=1, expose_len=0 -> back-to-back frames, expose 1 cycle each, no IDLE cycle between frame_done and erase.
REQ-040 abort during CONVERT cycle 3 -> IDLE next cycle, convert=0, busy=0, gray holds 2; async reset during READ -> all outputs 0 immediately.
